// File: rtl/data_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_bus_ctrl
//  Description : Converts the CPU's single-cycle data port into a req/ack
//                memory transaction, stalling the CPU until completion.
//                Optional feature macro: BUS_TIMEOUT_EN -- compiles in a
//                BUSY-cycle watchdog that aborts a transaction after
//                TIMEOUT_CYCLES, returns ERR_RDATA and sets sticky bus_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_mem_we;
  logic [3:0]  r_mem_sel;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        w_start;
  logic        w_timeout;

  // A transaction is accepted only from IDLE; cpu_ce in DONE is ignored.
  assign w_start = (r_state == ST_IDLE) && cpu_ce;

`ifdef BUS_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_busy_cnt;
  logic               r_bus_err;

  // Abort on the last allowed BUSY cycle if the memory still has not acked.
  assign w_timeout = (r_state == ST_BUSY) && !mem_ack &&
                     (r_busy_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  // Count BUSY cycles; restarts from zero at every accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_cnt <= '0;
    end else if (w_start) begin
      r_busy_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      r_busy_cnt <= r_busy_cnt + c_CNT_W'(1);
    end
  end

  // Sticky error flag: once a timeout happens it holds until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  logic w_unused_cfg;

  // Without the watchdog BUSY waits for mem_ack indefinitely.
  assign w_timeout    = 1'b0;
  assign bus_err      = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_next_state = r_state;
    stall_req    = 1'b0;
    mem_req      = 1'b0;
    cpu_rdata    = 32'h0;
    case (r_state)
      ST_IDLE: begin
        stall_req = cpu_ce;
        if (cpu_ce) begin
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_req = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack || w_timeout) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_rdata    = r_rdata;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the CPU request once; later cpu_* changes cannot reach mem_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_we    <= 1'b0;
      r_mem_sel   <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else if (w_start) begin
      r_mem_we    <= cpu_we;
      r_mem_sel   <= cpu_sel;
      r_mem_addr  <= cpu_addr;
      r_mem_wdata <= cpu_wdata;
    end
  end

  // Read data register: memory data on a read ack, zero for writes,
  // error pattern on a watchdog abort. Acks outside BUSY are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'h0;
    end else if (r_state == ST_BUSY) begin
      if (mem_ack) begin
        r_rdata <= r_mem_we ? 32'h0 : mem_rdata;
      end else if (w_timeout) begin
        r_rdata <= ERR_RDATA;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_sel   = r_mem_sel;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_bus_ctrl
//  Description : Self-checking bench for data_bus_ctrl. Expected per-cycle
//                outputs are derived from each transaction's ack delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_ctrl;

  localparam int unsigned c_TO  = 4;
  localparam logic [31:0] c_ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall_req;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  data_bus_ctrl #(
    .TIMEOUT_CYCLES (c_TO),
    .ERR_RDATA      (c_ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_ce    (cpu_ce),
    .cpu_we    (cpu_we),
    .cpu_sel   (cpu_sel),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall_req (stall_req),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must be in the current cycle.
  bit          chk_en = 1'b0;
  logic        exp_stall;
  logic        exp_req;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic        exp_we;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_req", {31'b0, stall_req}, {31'b0, exp_stall});
      chk("mem_req",   {31'b0, mem_req},   {31'b0, exp_req});
      chk("cpu_rdata", cpu_rdata,          exp_rdata);
      chk("bus_err",   {31'b0, bus_err},   {31'b0, exp_err});
      if (exp_req) begin
        chk("mem_we",    {31'b0, mem_we},  {31'b0, exp_we});
        chk("mem_sel",   {28'b0, mem_sel}, {28'b0, exp_sel});
        chk("mem_addr",  mem_addr,         exp_addr);
        chk("mem_wdata", mem_wdata,        exp_wdata);
      end
    end
  end

  // Activity monitor for latency and pulse-count checks.
  int   cyc        = 0;
  int   stall_cnt  = 0;
  int   req_pulses = 0;
  int   last_rise  = 0;
  int   prev_rise  = 0;
  logic prev_req   = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (stall_req === 1'b1) stall_cnt++;
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      req_pulses++;
      prev_rise = last_rise;
      last_rise = cyc;
    end
    prev_req = mem_req;
  end

  task automatic set_exp(input logic s, input logic r, input logic [31:0] rd);
    exp_stall = s;
    exp_req   = r;
    exp_rdata = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_ce  = 1'b0;
      mem_ack = 1'b0;
      set_exp(1'b0, 1'b0, 32'h0);
    end
  endtask

  // One CPU access: IDLE request cycle, BUSY for (delay+1) cycles (or the
  // timeout length when no ack comes), then one DONE cycle.
  task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int delay,
                      input bit no_ack, input bit ce_in_done);
    int n;
    n = no_ack ? int'(c_TO) : delay + 1;
    @(posedge clk); #1;
    cpu_ce    = 1'b1;
    cpu_we    = we;
    cpu_sel   = sel;
    cpu_addr  = addr;
    cpu_wdata = wd;
    mem_ack   = (delay > 0);       // stray ack outside BUSY must be ignored
    mem_rdata = $urandom;
    exp_we    = we;
    exp_sel   = sel;
    exp_addr  = addr;
    exp_wdata = wd;
    set_exp(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_we    = ~we;             // CPU inputs scrambled while busy
      cpu_sel   = ~sel;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      mem_ack   = !no_ack && (i == n - 1);
      mem_rdata = mem_ack ? rd : $urandom;
      set_exp(1'b1, 1'b1, 32'h0);
    end
    @(posedge clk); #1;
    cpu_ce    = ce_in_done;
    mem_ack   = 1'b1;              // spurious ack in DONE
    mem_rdata = $urandom;
    if (no_ack) exp_err = 1'b1;
    set_exp(1'b0, 1'b0, no_ack ? c_ERR : (we ? 32'h0 : rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    cpu_ce    = 1'b0;
    cpu_we    = 1'b0;
    cpu_sel   = 4'h0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    exp_err   = 1'b0;
    set_exp(1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_stall",     {31'b0, stall_req}, 32'h0);
    chk("rst_mem_req",   {31'b0, mem_req},   32'h0);
    chk("rst_cpu_rdata", cpu_rdata,          32'h0);
    chk("rst_bus_err",   {31'b0, bus_err},   32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_mem_wdata", mem_wdata,          32'h0);
    cpu_ce = 1'b1;
    #1;
    chk("rst_stall_follows_ce", {31'b0, stall_req}, 32'h1);
    cpu_ce = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read, ack in first BUSY cycle.
    stall_cnt = 0;
    xfer(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0);
    idle(1);
    chk("rd_min_stall_cycles", 32'(stall_cnt), 32'd2);

    // Write, ack delayed 3 cycles.
    stall_cnt = 0;
    xfer(1'b1, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD, 32'h5555_5555, 3, 1'b0, 1'b0);
    idle(1);
    chk("wr_delay3_stall_cycles", 32'(stall_cnt), 32'd5);

    // Back-to-back reads with cpu_ce held high.
    req_pulses = 0;
    xfer(1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h0404_0404, 0, 1'b0, 1'b1);
    xfer(1'b0, 4'hF, 32'h0000_0008, 32'h0, 32'h0808_0808, 0, 1'b0, 1'b0);
    idle(1);
    chk("b2b_req_pulses", 32'(req_pulses), 32'd2);
    chk("b2b_rise_spacing", 32'(last_rise - prev_rise), 32'd3);

    // Further patterns: byte-lane read with delay, full-ones write.
    xfer(1'b0, 4'b1000, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    idle(1);
    xfer(1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1357_9BDF, 0, 1'b0, 1'b0);
    idle(2);

`ifdef BUS_TIMEOUT_EN
    stall_cnt = 0;
    xfer(1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    idle(1);
    chk("to_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("to_bus_err", {31'b0, bus_err}, 32'h1);
    xfer(1'b0, 4'hF, 32'h0000_0034, 32'h0, 32'h1111_2222, 0, 1'b0, 1'b0);
    idle(1);
    chk("to_bus_err_sticky", {31'b0, bus_err}, 32'h1);
`endif

    // Reset asserted in the second BUSY cycle.
    @(posedge clk); #1;
    cpu_ce    = 1'b1;
    cpu_we    = 1'b0;
    cpu_sel   = 4'hF;
    cpu_addr  = 32'h0000_0040;
    cpu_wdata = 32'h0;
    mem_ack   = 1'b0;
    exp_we    = 1'b0;
    exp_sel   = 4'hF;
    exp_addr  = 32'h0000_0040;
    exp_wdata = 32'h0;
    set_exp(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_exp(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("arst_mem_req",   {31'b0, mem_req},   32'h0);
    chk("arst_stall_ce1", {31'b0, stall_req}, 32'h1);
    chk("arst_cpu_rdata", cpu_rdata,          32'h0);
    chk("arst_mem_addr",  mem_addr,           32'h0);
    chk("arst_bus_err",   {31'b0, bus_err},   32'h0);
    cpu_ce = 1'b0;
    #1;
    chk("arst_stall_ce0", {31'b0, stall_req}, 32'h0);
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cpu_ce    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_9999;
    set_exp(1'b0, 1'b0, 32'h0);
    chk_en = 1'b1;
    idle(2);
    xfer(1'b0, 4'b0110, 32'h0000_0044, 32'h0, 32'h2468_ACE0, 2, 1'b0, 1'b0);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before abort (used only with BUS_TIMEOUT_EN).
- ERR_RDATA, 32'h0000_0000, read data returned on timeout.
REQ-002 The port list SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, asynchronous active-low reset.
- cpu_ce, in, 1, CPU data-port access enable (openmips ram_ce_o).
- cpu_we, in, 1, 1 = write, 0 = read.
- cpu_sel, in, 4, byte lane select.
- cpu_addr, in, 32, byte address.
- cpu_wdata, in, 32, write data.
- cpu_rdata, out, 32, read data to CPU.
- stall_req, out, 1, pipeline stall request to CPU.
- mem_req, out, 1, memory-side request.
- mem_we, out, 1, registered copy of cpu_we.
- mem_sel, out, 4, registered copy of cpu_sel.
- mem_addr, out, 32, registered copy of cpu_addr.
- mem_wdata, out, 32, registered copy of cpu_wdata.
- mem_rdata, in, 32, memory read data; valid when mem_ack = 1.
- mem_ack, in, 1, single-cycle completion strobe from memory.
- bus_err, out, 1, sticky timeout flag.

Function
REQ-003 The block SHALL convert the CPU's single-cycle data port into a req/ack transaction, stalling the CPU until the transaction completes.
REQ-004 The FSM SHALL have three states, IDLE, BUSY and DONE, with the following transitions.
- IDLE -> BUSY when cpu_ce = 1.
- BUSY -> DONE on mem_ack = 1 (or on timeout, see REQ-014).
- DONE -> IDLE unconditionally.
REQ-005 In IDLE, stall_req SHALL equal cpu_ce combinationally, and cpu_we, cpu_sel, cpu_addr and cpu_wdata SHALL be latched into the mem_* registers at the edge that enters BUSY.
REQ-006 In BUSY, mem_req SHALL be 1, stall_req SHALL be 1, and all mem_* outputs SHALL remain stable until acknowledged.
REQ-007 On the mem_ack edge in BUSY, mem_rdata SHALL be captured into the rdata register for reads, and mem_req SHALL drop to 0 in the next cycle.
REQ-008 In DONE, stall_req SHALL be 0 and cpu_rdata SHALL present the captured data; in all other states cpu_rdata SHALL be 0.
- For writes, cpu_rdata SHALL be 0 in DONE as well.
REQ-009 Latency SHALL be as follows.
- Minimum transaction is 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles, when mem_ack arrives in the first BUSY cycle.
- Each cycle of ack delay adds exactly one stall cycle.
REQ-010 A mem_ack received outside BUSY SHALL be ignored and SHALL NOT change any state or output.
REQ-011 cpu_ce = 1 in the DONE cycle SHALL NOT start a transaction; back-to-back accesses SHALL re-enter BUSY from IDLE on the following cycle.
REQ-012 cpu_* inputs changing while in BUSY SHALL NOT affect mem_* outputs.

Reset
REQ-013 rst = 0 SHALL immediately, without waiting for clk, force the following, including mid-transaction.
- State to IDLE.
- mem_req, mem_we, mem_sel, mem_addr, mem_wdata, the rdata register, cpu_rdata and bus_err to 0.
- The timeout counter to 0.
- stall_req is not forced; it then follows REQ-005 (it equals cpu_ce while the block is in IDLE).

Configuration
REQ-014 With the macro BUS_TIMEOUT_EN defined, a BUSY-cycle counter SHALL be compiled in and behave as follows.
- Reaching TIMEOUT_CYCLES without mem_ack forces BUSY -> DONE.
- cpu_rdata = ERR_RDATA in that DONE cycle.
- bus_err is set and stays 1 until reset.
- The counter clears on entering BUSY.
REQ-015 Without BUS_TIMEOUT_EN, no counter SHALL exist, bus_err SHALL be tied 0, and BUSY SHALL wait for mem_ack indefinitely.

Verification
REQ-016 Read with ack in the first BUSY cycle: addr = 0x0000_0010, mem_rdata = 0x1234_5678.
- stall_req is high for 2 cycles.
- cpu_rdata = 0x1234_5678 in DONE.
- mem_addr = 0x10 while mem_req = 1.
REQ-017 Write with ack delayed 3 cycles: we = 1, sel = 4'b0011, wdata = 0xAABB_CCDD.
- stall_req is high for 5 cycles.
- mem_wdata and mem_sel stay stable throughout BUSY.
- cpu_rdata = 0.
REQ-018 Back-to-back reads to 0x4 then 0x8 with cpu_ce held high:
- two distinct mem_req pulses.
- one IDLE cycle between them.
- each returns its own data.
REQ-019 Reset asserted in the second BUSY cycle:
- mem_req is 0 before the next clk edge.
- the state returns to IDLE.
- a spurious mem_ack afterwards is ignored.
REQ-020 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, a read with no ack:
- DONE is reached after 4 BUSY cycles.
- cpu_rdata = ERR_RDATA.
- bus_err stays 1 through later successful accesses until reset.
